// File: rtl/ir_frame_decoder.sv
// NEC-style IR frame decoder: 20 data bits plus repeat frames, widths measured in prescaled ticks.
// Optional IR_GLITCH_FILTER_EN: line level must be stable for 3 ticks before it is accepted.
module ir_frame_decoder #(
  parameter int TICK_DIV   = 1000,
  parameter int LEAD_MARK  = 900,
  parameter int LEAD_SPACE = 450,
  parameter int REP_SPACE  = 225,
  parameter int BIT_MARK   = 56,
  parameter int ZERO_SPACE = 56,
  parameter int ONE_SPACE  = 169,
  parameter int REP_WINDOW = 11000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_in,
  output logic [19:0] ir_data,
  output logic        repeat_en,
  output logic        data_strobe,
  output logic        frame_err,
  output logic        busy
);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [15:0] LM_LO = 16'(LEAD_MARK - LEAD_MARK/4),   LM_HI = 16'(LEAD_MARK + LEAD_MARK/4);
  localparam logic [15:0] LS_LO = 16'(LEAD_SPACE - LEAD_SPACE/4), LS_HI = 16'(LEAD_SPACE + LEAD_SPACE/4);
  localparam logic [15:0] RS_LO = 16'(REP_SPACE - REP_SPACE/4),   RS_HI = 16'(REP_SPACE + REP_SPACE/4);
  localparam logic [15:0] BM_LO = 16'(BIT_MARK - BIT_MARK/4),     BM_HI = 16'(BIT_MARK + BIT_MARK/4);
  localparam logic [15:0] ZS_LO = 16'(ZERO_SPACE - ZERO_SPACE/4), ZS_HI = 16'(ZERO_SPACE + ZERO_SPACE/4);
  localparam logic [15:0] OS_LO = 16'(ONE_SPACE - ONE_SPACE/4),   OS_HI = 16'(ONE_SPACE + ONE_SPACE/4);
  localparam logic [15:0] LSP_MAX = (LS_HI > RS_HI) ? LS_HI : RS_HI;
  localparam logic [15:0] BSP_MAX = (ZS_HI > OS_HI) ? ZS_HI : OS_HI;
  localparam logic [15:0] RW = 16'(REP_WINDOW);

  typedef enum logic [2:0] {IDLE, LEAD_MARK_S, LEAD_SPACE_S, BIT_MARK_S, BIT_SPACE_S, STOP_MARK_S} state_t;

  function automatic logic in_tol(input logic [15:0] w, input logic [15:0] lo, input logic [15:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  state_t        state, state_n;
  logic [DW-1:0] div;
  logic          tick, s1, s2, lvl, lvl_d, fall, rise, edge_any;
  logic [15:0]   width, win;
  logic [19:0]   shadow;
  logic [4:0]    idx;
  logic          hist, rep_ok, rep_frm;
  logic          err, acc_d, acc_r, shift, bit_v, clr_idx, set_rep, clr_rep;

  assign tick = (div == DW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div <= '0; s1 <= 1'b1; s2 <= 1'b1;
    end else begin
      div <= tick ? '0 : div + DW'(1);
      s1  <= ir_in;
      s2  <= s1;
    end

`ifdef IR_GLITCH_FILTER_EN
  logic [1:0] stab;
  logic       filt;
  // the third consecutive tick with a differing level commits the new level
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      filt <= 1'b1; stab <= '0;
    end else if (s2 == filt) stab <= '0;
    else if (tick) begin
      if (stab == 2'd2) begin filt <= s2; stab <= '0; end
      else stab <= stab + 2'd1;
    end
  assign lvl = filt;
`else
  assign lvl = s2;
`endif

  assign fall     = lvl_d & ~lvl;
  assign rise     = ~lvl_d & lvl;
  assign edge_any = fall | rise;
  assign busy     = (state != IDLE);

  always_comb begin
    state_n = state; err = 1'b0; acc_d = 1'b0; acc_r = 1'b0;
    shift = 1'b0; bit_v = 1'b0; clr_idx = 1'b0; set_rep = 1'b0; clr_rep = 1'b0;
    case (state)
      IDLE: if (fall) state_n = LEAD_MARK_S;
      LEAD_MARK_S:
        if (rise) begin
          if (in_tol(width, LM_LO, LM_HI)) state_n = LEAD_SPACE_S; else err = 1'b1;
        end else if (width > LM_HI) err = 1'b1;
      LEAD_SPACE_S:
        if (fall) begin
          if (in_tol(width, LS_LO, LS_HI)) begin state_n = BIT_MARK_S; clr_idx = 1'b1; clr_rep = 1'b1; end
          else if (in_tol(width, RS_LO, RS_HI)) begin state_n = STOP_MARK_S; set_rep = 1'b1; end
          else err = 1'b1;
        end else if (width > LSP_MAX) err = 1'b1;
      BIT_MARK_S:
        if (rise) begin
          if (in_tol(width, BM_LO, BM_HI)) state_n = BIT_SPACE_S; else err = 1'b1;
        end else if (width > BM_HI) err = 1'b1;
      BIT_SPACE_S:
        if (fall) begin
          if (in_tol(width, ZS_LO, ZS_HI)) shift = 1'b1;
          else if (in_tol(width, OS_LO, OS_HI)) begin shift = 1'b1; bit_v = 1'b1; end
          else err = 1'b1;
          if (shift) state_n = (idx == 5'd19) ? STOP_MARK_S : BIT_MARK_S;
        end else if (width > BSP_MAX) err = 1'b1;
      STOP_MARK_S:
        if (rise) begin
          if (!in_tol(width, BM_LO, BM_HI)) err = 1'b1;
          else if (!rep_frm) acc_d = 1'b1;
          else if (rep_ok) acc_r = 1'b1;
          else err = 1'b1;
          state_n = IDLE;
        end else if (width > BM_HI) err = 1'b1;
      default: state_n = IDLE;
    endcase
    if (err) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE; lvl_d <= 1'b1; width <= '0; win <= '0; shadow <= '0; idx <= '0;
      hist <= 1'b0; rep_ok <= 1'b0; rep_frm <= 1'b0;
      ir_data <= '0; data_strobe <= 1'b0; repeat_en <= 1'b0; frame_err <= 1'b0;
    end else begin
      state <= state_n;
      lvl_d <= lvl;
      // an edge wins over a same-cycle tick; the FSM already judged the pre-clear width
      if (edge_any) width <= '0;
      else if (tick && width != 16'hFFFF) width <= width + 16'd1;
      if (acc_d || acc_r) win <= '0;
      else if (tick && win != 16'hFFFF) win <= win + 16'd1;
      if (acc_d) hist <= 1'b1;
      else if (win > RW) hist <= 1'b0;
      if (state == IDLE && fall) rep_ok <= hist && (win <= RW);
      if (set_rep) rep_frm <= 1'b1;
      else if (clr_rep) rep_frm <= 1'b0;
      if (clr_idx) idx <= '0;
      else if (shift) idx <= idx + 5'd1;
      if (shift) shadow <= {bit_v, shadow[19:1]};
      if (acc_d) ir_data <= shadow;
      data_strobe <= acc_d;
      repeat_en   <= acc_r;
      frame_err   <= err;
    end
endmodule

// File: tb/tb_ir_frame_decoder.sv
// Scoreboard bench for ir_frame_decoder; timing nominals scaled down so the run stays short.
module tb_ir_frame_decoder;
  localparam int TD = 10, LM = 48, LS = 24, RS = 12, BM = 4, ZS = 4, OS = 12, RW = 600;

  logic clk = 1'b0, rst = 1'b1, ir_in = 1'b1;
  logic [19:0] ir_data;
  logic repeat_en, data_strobe, frame_err, busy;

  always #5 clk = ~clk;

  ir_frame_decoder #(.TICK_DIV(TD), .LEAD_MARK(LM), .LEAD_SPACE(LS), .REP_SPACE(RS),
    .BIT_MARK(BM), .ZERO_SPACE(ZS), .ONE_SPACE(OS), .REP_WINDOW(RW)) dut (
    .clk(clk), .rst(rst), .ir_in(ir_in), .ir_data(ir_data), .repeat_en(repeat_en),
    .data_strobe(data_strobe), .frame_err(frame_err), .busy(busy));

  // kind: 0 = data accept, 1 = repeat accept, 2 = frame error
  typedef struct { int kind; logic [19:0] data; } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [19:0] data);
    exp_t e;
    e.kind = kind; e.data = data;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    int k;
    exp_t e;
    if (!rst && (data_strobe || repeat_en || frame_err)) begin
      chk("exclusive", 32'(data_strobe) + 32'(repeat_en) + 32'(frame_err), 32'd1);
      k = data_strobe ? 0 : (repeat_en ? 1 : 2);
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_pulse actual_kind=%0d expected=none", k);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", 32'(k), 32'(e.kind));
        chk("ir_data", 32'(ir_data), 32'(e.data));
      end
    end
  end

  task automatic level(input logic l, input int ticks);
    ir_in = l;
    repeat (ticks * TD) @(negedge clk);
  endtask

  // closing rising edge; accepted frames show their pulse 3 clk later
  task automatic close_frame(input int exp_kind);
    ir_in = 1'b1;
`ifndef IR_GLITCH_FILTER_EN
    repeat (3) @(negedge clk);
    if (exp_kind == 0) chk("strobe_latency", 32'(data_strobe), 32'd1);
    if (exp_kind == 1) chk("repeat_latency", 32'(repeat_en), 32'd1);
`endif
    level(1'b1, 20);
  endtask

  task automatic send_frame(input logic [19:0] d, input int nbits, input int badbit, input int exp_kind);
    level(1'b0, LM);
    level(1'b1, LS);
    for (int i = 0; i < nbits; i++) begin
      level(1'b0, BM);
      if (i == badbit) begin
        level(1'b1, 20);
        break;
      end
      level(1'b1, d[i] ? OS : ZS);
    end
    if (nbits == 20 && badbit < 0) begin
      level(1'b0, BM);
      close_frame(exp_kind);
    end
  endtask

  task automatic send_rep(input int exp_kind);
    level(1'b0, LM);
    level(1'b1, RS);
    level(1'b0, BM);
    close_frame(exp_kind);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ir_data", 32'(ir_data), 32'd0);
    chk("rst_strobe", 32'(data_strobe), 32'd0);
    chk("rst_repeat", 32'(repeat_en), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    level(1'b1, 5);

    push(2, 20'h0);
    send_rep(2);

`ifndef IR_GLITCH_FILTER_EN
    push(2, 20'h0);
`endif
    level(1'b0, 2);
`ifdef IR_GLITCH_FILTER_EN
    chk("glitch_busy", 32'(busy), 32'd0);
`endif
    level(1'b1, 20);

    push(0, 20'hABCDE);
    send_frame(20'hABCDE, 20, -1, 0);
    level(1'b1, 180);
    push(1, 20'hABCDE);
    send_rep(1);
    level(1'b1, 180);
    push(1, 20'hABCDE);
    send_rep(1);
    level(1'b1, 630);
    push(2, 20'hABCDE);
    send_rep(2);

    push(2, 20'hABCDE);
    send_frame(20'h12345, 20, 7, 2);
    chk("busy_after_err", 32'(busy), 32'd0);
    chk("data_kept", 32'(ir_data), 32'hABCDE);
    level(1'b1, 20);
    push(0, 20'h12345);
    send_frame(20'h12345, 20, -1, 0);

    send_frame(20'h3C3C3, 10, -1, -1);
    chk("busy_mid_frame", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_ir_data", 32'(ir_data), 32'd0);
    chk("async_rst_strobe", 32'(data_strobe), 32'd0);
    chk("async_rst_repeat", 32'(repeat_en), 32'd0);
    chk("async_rst_err", 32'(frame_err), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    level(1'b1, 10);
    push(0, 20'h00F0F);
    send_frame(20'h00F0F, 20, -1, 0);

    for (int i = 0; i < 1000 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
